// File: rtl/johnson_phase_ctrl.sv
// johnson_phase_ctrl: run controller for an 8-phase Johnson-ring timing generator.
// Optional single-step pacing (step_mode/step ports) when JOHNSON_PHASE_CTRL_STEP_EN is defined.
module johnson_phase_ctrl #(
  parameter int CW = 8
) (
  input  logic          clock,
  input  logic          resetn,
`ifdef JOHNSON_PHASE_CTRL_STEP_EN
  input  logic          step_mode,
  input  logic          step,
`endif
  input  logic          start,
  input  logic [CW-1:0] len,
  input  logic          hold,
  input  logic          abort,
  output logic [0:7]    T,
  output logic [2:0]    phase_idx,
  output logic [CW-1:0] rot_cnt,
  output logic          busy,
  output logic          done,
  output logic          err
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [0:3] ring, ring_nx;
  logic [CW-1:0] len_q, len_nx, cnt_nx;
  logic [2:0] idx;
  logic legal, adv;
`ifdef JOHNSON_PHASE_CTRL_STEP_EN
  assign adv = ~hold & (~step_mode | step);
`else
  assign adv = ~hold;
`endif
  always_comb begin
    legal = 1'b1;
    idx = 3'd0;
    case (ring)
      4'b1000: idx = 3'd0;
      4'b1100: idx = 3'd1;
      4'b1110: idx = 3'd2;
      4'b1111: idx = 3'd3;
      4'b0111: idx = 3'd4;
      4'b0011: idx = 3'd5;
      4'b0001: idx = 3'd6;
      4'b0000: idx = 3'd7;
      default: legal = 1'b0;
    endcase
  end
  always_comb begin
    state_nx = state;
    ring_nx = ring;
    len_nx = len_q;
    cnt_nx = rot_cnt;
    case (state)
      IDLE: if (start && len != '0) begin
        state_nx = RUN;
        ring_nx = 4'b1000;
        len_nx = len;
        cnt_nx = '0;
      end
      RUN: if (abort) begin
        state_nx = IDLE;
        ring_nx = 4'b0000;
      end else if (!legal) begin
        ring_nx = 4'b1000;
      end else if (adv) begin
        ring_nx = {~ring[3], ring[0:2]};
        if (ring == 4'b0000) begin
          cnt_nx = rot_cnt + 1'b1;
          // completion parks the ring at 0000 instead of wrapping into a new rotation
          if (cnt_nx == len_q) begin
            state_nx = DONE;
            ring_nx = 4'b0000;
          end
        end
      end
      default: begin
        state_nx = IDLE;
        ring_nx = 4'b0000;
      end
    endcase
  end
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      ring <= 4'b0000;
      len_q <= '0;
      rot_cnt <= '0;
    end else begin
      state <= state_nx;
      ring <= ring_nx;
      len_q <= len_nx;
      rot_cnt <= cnt_nx;
    end
  end
  assign busy = state == RUN;
  assign done = state == DONE;
  assign err = busy & ~legal;
  assign phase_idx = (busy && legal) ? idx : 3'd0;
  assign T = (busy && legal) ? (8'h80 >> idx) : 8'h00;
endmodule

// File: tb/tb_johnson_phase_ctrl.sv
// tb_johnson_phase_ctrl: vector table, hand corner sequences and random stimulus against a phase/rotation model.
module tb_johnson_phase_ctrl;
  localparam int CW = 8;
  logic clock = 0, resetn = 0, start = 0, hold = 0, abort = 0;
  logic step_mode = 0, step = 0;
  logic [CW-1:0] len = '0;
  logic [0:7] T;
  logic [2:0] phase_idx;
  logic [CW-1:0] rot_cnt;
  logic busy, done, err;
  int total = 0, pass = 0;
  int m_mode = 0, m_p = 0, m_r = 0, m_len = 0;
  bit m_bad = 0;
  typedef struct {bit s; int l; bit h; bit a; int t; bit b; bit d; int r;} vec_t;
  vec_t tbl[$];
  always #5 clock = ~clock;
  johnson_phase_ctrl #(.CW(CW)) dut (
    .clock(clock), .resetn(resetn),
`ifdef JOHNSON_PHASE_CTRL_STEP_EN
    .step_mode(step_mode), .step(step),
`endif
    .start(start), .len(len), .hold(hold), .abort(abort),
    .T(T), .phase_idx(phase_idx), .rot_cnt(rot_cnt), .busy(busy), .done(done), .err(err));
  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask
  task automatic cmp();
    bit run;
    run = (m_mode == 1) && !m_bad;
    check("T", int'(T), run ? (32'h80 >> m_p) : 0);
    check("phase_idx", int'(phase_idx), run ? m_p : 0);
    check("rot_cnt", int'(rot_cnt), m_r);
    check("busy", int'(busy), int'(m_mode == 1));
    check("done", int'(done), int'(m_mode == 2));
    check("err", int'(err), int'(m_mode == 1 && m_bad));
  endtask
  task automatic model_edge();
    case (m_mode)
      0: if (start && len != 0) begin m_mode = 1; m_p = 0; m_r = 0; m_len = int'(len); end
      1: if (abort) m_mode = 0;
         else if (m_bad) begin m_bad = 0; m_p = 0; end
         else if (!hold && (!step_mode || step)) begin
           if (m_p == 7) begin
             m_r++;
             if (m_r == m_len) m_mode = 2; else m_p = 0;
           end else m_p++;
         end
      default: m_mode = 0;
    endcase
  endtask
  task automatic apply(input bit s, input int l, input bit h, input bit a);
    start = s; len = l[CW-1:0]; hold = h; abort = a;
    @(posedge clock);
    model_edge();
    #1;
    cmp();
  endtask
  initial begin
    int nb, nd, nt, hc, ns;
    bit h;
    #12;
    cmp();
    @(posedge clock); #1 resetn = 1;
    tbl.push_back('{1, 1, 0, 0, 'h80, 1, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 'h40, 1, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 'h20, 1, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 'h10, 1, 0, 0});
    tbl.push_back('{1, 7, 0, 0, 'h08, 1, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 'h04, 1, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 'h02, 1, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 'h01, 1, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 'h00, 0, 1, 1});
    tbl.push_back('{1, 5, 0, 0, 'h00, 0, 0, 1});
    tbl.push_back('{1, 0, 0, 0, 'h00, 0, 0, 1});
    tbl.push_back('{0, 0, 0, 1, 'h00, 0, 0, 1});
    foreach (tbl[i]) begin
      apply(tbl[i].s, tbl[i].l, tbl[i].h, tbl[i].a);
      check("tbl_T", int'(T), tbl[i].t);
      check("tbl_busy", int'(busy), int'(tbl[i].b));
      check("tbl_done", int'(done), int'(tbl[i].d));
      check("tbl_rot", int'(rot_cnt), tbl[i].r);
    end
    apply(1, 3, 0, 0);
    nb = int'(busy); nd = 0; nt = 0; hc = 0;
    for (int k = 0; k < 40; k++) begin
      h = (T == 8'h08) && hc < 5 && rot_cnt == 0;
      if (h) hc++;
      apply(0, 0, h, 0);
      nb += int'(busy); nd += int'(done); nt += int'(T == 8'h08 && rot_cnt == 0);
    end
    check("hold_busy_cycles", nb, 29);
    check("hold_t4_cycles", nt, 6);
    check("hold_done_pulses", nd, 1);
    check("hold_rot_final", int'(rot_cnt), 3);
    apply(1, 0, 0, 0);
    check("len0_busy", int'(busy), 0);
    apply(1, 2, 0, 0);
    nb = int'(busy); nd = 0;
    for (int k = 0; k < 20; k++) begin apply(0, 0, 0, 0); nb += int'(busy); nd += int'(done); end
    check("len2_busy_cycles", nb, 16);
    check("len2_done_pulses", nd, 1);
    apply(1, 4, 0, 0);
    repeat (13) apply(0, 0, 0, 0);
    check("abort_pre_phase", int'(phase_idx), 5);
    check("abort_pre_rot", int'(rot_cnt), 1);
    apply(0, 0, 1, 1);
    check("abort_T", int'(T), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_rot", int'(rot_cnt), 1);
    nd = 0;
    repeat (3) begin apply(0, 0, 0, 0); nd += int'(done); end
    check("abort_no_done", nd, 0);
    apply(1, 1, 0, 0);
    nb = int'(busy); nd = 0;
    for (int k = 0; k < 10; k++) begin apply(0, 0, 0, 0); nb += int'(busy); nd += int'(done); end
    check("after_abort_busy", nb, 8);
    check("after_abort_done", nd, 1);
    apply(1, 2, 0, 0);
    repeat (3) apply(0, 0, 0, 0);
    force dut.ring = 4'b0101;
    #1 release dut.ring;
    #1 m_bad = 1;
    cmp();
    check("illegal_err", int'(err), 1);
    check("illegal_T", int'(T), 0);
    apply(0, 0, 0, 0);
    check("recover_T", int'(T), 'h80);
    check("recover_err", int'(err), 0);
    check("recover_rot", int'(rot_cnt), 0);
    repeat (20) apply(0, 0, 0, 0);
    apply(1, 3, 0, 0);
    repeat (5) apply(0, 0, 0, 0);
    #2 resetn = 0;
    #1 m_mode = 0; m_p = 0; m_r = 0; m_bad = 0;
    cmp();
    check("areset_busy", int'(busy), 0);
    check("areset_T", int'(T), 0);
    @(posedge clock); #1 resetn = 1;
    apply(1, 255, 0, 0);
    nb = int'(busy); nd = 0;
    for (int k = 0; k < 2050; k++) begin apply(0, 0, 0, 0); nb += int'(busy); nd += int'(done); end
    check("max_busy_cycles", nb, 2040);
    check("max_rot", int'(rot_cnt), 255);
    check("max_done", nd, 1);
`ifdef JOHNSON_PHASE_CTRL_STEP_EN
    step_mode = 1; step = 0;
    apply(1, 1, 0, 0);
    ns = 0; nd = 0;
    for (int k = 0; k < 40; k++) begin
      step = (k % 3 == 2);
      if (step) ns++;
      apply(0, 0, 0, 0);
      if (done) begin nd++; check("step_count_at_done", ns, 8); end
    end
    check("step_done_pulses", nd, 1);
    step_mode = 0; step = 0;
`else
    ns = 0;
`endif
    for (int k = 0; k < 3000; k++)
      apply($urandom_range(0, 2) == 0, int'($urandom_range(0, 3)), $urandom_range(0, 3) == 0, $urandom_range(0, 39) == 0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
